alu_seq: RTL



---
 rtl/alu_seq.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift ops, iterative unsigned MUL/DIVU/REMU.
// Results and flags are registered and held while the consumer stalls.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [3:0] {
        OpAdd  = 4'h0, OpAdc  = 4'h1, OpSub  = 4'h2, OpSbc  = 4'h3,
        OpAnd  = 4'h4, OpOr   = 4'h5, OpNor  = 4'h6, OpNad  = 4'h7,
        OpXor  = 4'h8, OpCmp  = 4'h9, OpShl  = 4'hA, OpShr  = 4'hB,
        OpAsr  = 4'hC, OpMul  = 4'hD, OpDivu = 4'hE, OpRemu = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    state_e           state_q, state_d;
    alu_op_e          op, op_q;
    logic             accept, long_op, last_step, load_res;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dsr_q;
    logic             bz_q;
    logic [WIDTH-1:0] result_q, res_d;
    logic             z_q, n_q, c_q, v_q, c_d, v_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, borrow_in;
    logic [WIDTH:0]   arith, shl_w, shr_w, asr_w;
    logic [SHW-1:0]   shamt;

    logic [WIDTH:0]   mul_sum, rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    assign op        = alu_op_e'(alu_op);
    assign long_op   = op inside {OpMul, OpDivu, OpRemu};
    assign accept    = in_valid & in_ready;
    assign last_step = (state_q == StBusy) && (cnt_q == CntLast);
    assign load_res  = (accept & ~long_op) | last_step;

    // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
    assign shamt = operand_b[SHW-1:0];
    assign shl_w = {1'b0, operand_a} << shamt;
    assign shr_w = {operand_a, 1'b0} >> shamt;
    assign asr_w = $signed({operand_a, 1'b0}) >>> shamt;

    always_comb begin
        sc_res    = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        arith     = '0;
        borrow_in = carry_in & (op == OpSbc);
        unique case (op)
            OpAdd, OpAdc: begin
                arith  = {1'b0, operand_a} + {1'b0, operand_b}
                       + {{WIDTH{1'b0}}, carry_in & (op == OpAdc)};
                sc_res = arith[WIDTH-1:0];
                sc_c   = arith[WIDTH];
                sc_v   = (operand_a[WIDTH-1] == operand_b[WIDTH-1])
                       & (arith[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OpSub, OpSbc, OpCmp: begin
                arith  = {1'b0, operand_a} - {1'b0, operand_b} - {{WIDTH{1'b0}}, borrow_in};
                sc_res = arith[WIDTH-1:0];
                sc_c   = arith[WIDTH];
                sc_v   = (operand_a[WIDTH-1] != operand_b[WIDTH-1])
                       & (arith[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OpAnd: sc_res = operand_a & operand_b;
            OpOr:  sc_res = operand_a | operand_b;
            OpNor: sc_res = ~(operand_a | operand_b);
            OpNad: sc_res = ~(operand_a & operand_b);
            OpXor: sc_res = operand_a ^ operand_b;
            OpShl: begin
                sc_res = shl_w[WIDTH-1:0];
                sc_c   = shl_w[WIDTH];
            end
            OpShr: begin
                sc_res = shr_w[WIDTH:1];
                sc_c   = shr_w[0];
            end
            OpAsr: begin
                sc_res = asr_w[WIDTH:1];
                sc_c   = asr_w[0];
            end
            OpMul, OpDivu, OpRemu: begin
                sc_res = '0;
            end
        endcase
    end

    // One iteration: MUL shifts {hi,lo} right after a conditional add; DIV/REM shifts left
    // and keeps the trial subtraction when it does not borrow.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, dsr_q};
        rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;
        if (op_q == OpMul) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (rem_ge) begin
            hi_d = rem_sub;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = rem_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        res_d = sc_res;
        c_d   = sc_c;
        v_d   = sc_v;
        if (state_q == StBusy) begin
            unique case (op_q)
                OpMul: begin
                    res_d = lo_d;
                    c_d   = |hi_d;
                    v_d   = 1'b0;
                end
                OpDivu: begin
                    res_d = lo_d;
                    c_d   = 1'b0;
                    v_d   = bz_q;
                end
                OpRemu: begin
                    res_d = hi_d;
                    c_d   = 1'b0;
                    v_d   = bz_q;
                end
                default: begin
                    res_d = '0;
                    c_d   = 1'b0;
                    v_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = long_op ? StBusy : StDone;
            StBusy: if (last_step) state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    if (!in_valid)    state_d = StIdle;
                    else if (long_op) state_d = StBusy;
                    else              state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StBusy: in_ready = 1'b0;
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OpAdd;
            bz_q     <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            if (accept && long_op) begin
                op_q  <= op;
                bz_q  <= (operand_b == '0);
                cnt_q <= '0;
                hi_q  <= '0;
                if (op == OpMul) begin
                    dsr_q <= operand_a;
                    lo_q  <= operand_b;
                end else begin
                    dsr_q <= operand_b;
                    lo_q  <= operand_a;
                end
            end else if (state_q == StBusy) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + SHW'(1);
            end
            if (load_res) begin
                result_q <= res_d;
                z_q      <= (res_d == '0);
                n_q      <= res_d[WIDTH-1];
                c_q      <= c_d;
                v_q      <= v_d;
            end
        end
    end

    assign result = result_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule
